// File: rtl/logic_op_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_pkg
// Purpose  : Opcode, FSM state and width definitions for the logic-op arbiter.
// Revision : 1.0  initial release
// ============================================================================
package logic_op_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/logic_op_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_arbiter_if
// Purpose  : Two requester ports, one response port and busy of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface logic_op_arbiter_if;
    import logic_op_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [1:0]        req0_op;
    logic [DATA_W-1:0] req0_A;
    logic [DATA_W-1:0] req0_B;
    logic              req1_valid;
    logic              req1_ready;
    logic [1:0]        req1_op;
    logic [DATA_W-1:0] req1_A;
    logic [DATA_W-1:0] req1_B;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_S;
    logic              busy;

    modport master (
        output req0_valid, req0_op, req0_A, req0_B,
        output req1_valid, req1_op, req1_A, req1_B,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_S, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_A, req0_B,
        input  req1_valid, req1_op, req1_A, req1_B,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_S, busy
    );

endinterface
`default_nettype wire

// File: rtl/logic_unit_32.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_32
// Purpose  : Combinational 32-bit NOT/AND/OR/XOR unit built from bit gates.
// Revision : 1.0  initial release
// ============================================================================
module logic_unit_32
    import logic_op_pkg::*;
(
    input  wire logic [1:0]        op,
    input  wire logic [DATA_W-1:0] A,
    input  wire logic [DATA_W-1:0] B,
    output logic      [DATA_W-1:0] S
);

    logic [DATA_W-1:0] w_not;
    logic [DATA_W-1:0] w_and;
    logic [DATA_W-1:0] w_or;
    logic [DATA_W-1:0] w_xor;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign w_not[i] = ~A[i];
        assign w_and[i] = A[i] & B[i];
        assign w_or[i]  = A[i] | B[i];
        assign w_xor[i] = A[i] ^ B[i];
    end

    always_comb begin
        S = w_not;
        case (op)
            OP_NOT:  S = w_not;
            OP_AND:  S = w_and;
            OP_OR:   S = w_or;
            OP_XOR:  S = w_xor;
            default: S = w_not;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_arbiter
// Purpose  : Round-robin share of one logic unit between two requesters.
// Revision : 1.0  initial release
// ============================================================================
module logic_op_arbiter
    import logic_op_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    logic_op_arbiter_if.slave bus
);

    state_e            r_state;
    logic              r_ptr;
    logic              r_id;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] w_s;
    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;

    // Reset masks the grant so a same-cycle reset never shows a handshake.
    assign w_idle = (r_state == ST_IDLE) && !reset;
    assign w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid || !r_ptr);
    assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid ||  r_ptr);

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_S      = r_s;
    assign bus.busy       = r_busy;

    logic_unit_32 u_logic_unit (
        .op (r_op),
        .A  (r_a),
        .B  (r_b),
        .S  (w_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_op        <= 2'b00;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_op    <= w_gnt1 ? bus.req1_op : bus.req0_op;
                        r_a     <= w_gnt1 ? bus.req1_A  : bus.req0_A;
                        r_b     <= w_gnt1 ? bus.req1_B  : bus.req0_B;
                        r_id    <= w_gnt1;
                        // Pointer moves to the requester that lost this round.
                        r_ptr   <= ~w_gnt1;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_s         <= w_s;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_arbiter
// Purpose  : Scoreboard bench for logic_op_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_op_arbiter;
    import logic_op_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] s;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t q[$];
    rsp_t r_exp;
    logic m_ptr;
    logic m_gnt;

    always #5 clk = ~clk;

    logic_op_arbiter_if bus ();

    logic_op_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Monitor: model the arbitration, push expected results on grant, pop on accept.
    initial begin
        m_ptr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                m_ptr = 1'b0;
            end else begin
                if (bus.req0_ready || bus.req1_ready) begin
                    m_gnt = (bus.req0_valid && bus.req1_valid) ? m_ptr : bus.req1_valid;
                    check("grant_id", bus.req1_ready, m_gnt);
                    check("grant_onehot", bus.req0_ready & bus.req1_ready, 0);
                    if (m_gnt)
                        q.push_back({1'b1, model(bus.req1_op, bus.req1_A, bus.req1_B)});
                    else
                        q.push_back({1'b0, model(bus.req0_op, bus.req0_A, bus.req0_B)});
                    m_ptr = ~m_gnt;
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        r_exp = q.pop_front();
                        check("rsp_id", bus.rsp_id, r_exp.id);
                        check("rsp_S", bus.rsp_S, r_exp.s);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int r);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
                tick();
                return;
            end
        end
        check("timeout_grant", 0, 1);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) return;
        end
        check("timeout_rsp", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && !bus.rsp_valid && q.size() == 0) return;
        end
        check("timeout_drain", 0, 1);
    endtask

    int g[4];
    int n;

    initial begin
        reset          = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_op    = 2'b00;
        bus.req0_A     = '0;
        bus.req0_B     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 2'b00;
        bus.req1_A     = '0;
        bus.req1_B     = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_busy", bus.busy, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
        end
        check("rst_rsp_S", bus.rsp_S, 0);
        check("rst_rsp_id", bus.rsp_id, 0);

        // Single request, NOT
        tick();
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b00;
        bus.req0_A     = 32'h0000FFFF;
        bus.req0_B     = 32'h12345678;
        @(negedge clk);
        check("single_ready0_c0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("single_rsp_valid_c1", bus.rsp_valid, 0);
        check("single_busy_c1", bus.busy, 1);
        tick();
        @(negedge clk);
        check("single_rsp_valid_c2", bus.rsp_valid, 1);
        check("single_rsp_S", bus.rsp_S, 32'hFFFF0000);
        check("single_rsp_id", bus.rsp_id, 0);
        drain();

        // Contention, XOR
        tick();
        do_reset();
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b11;
        bus.req0_A     = 32'hAAAA5555;
        bus.req0_B     = 32'hFFFF0000;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b11;
        bus.req1_A     = 32'hAAAA5555;
        bus.req1_B     = 32'hFFFF0000;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                g[n] = 0;
                n++;
            end else if (bus.req1_ready) begin
                g[n] = 1;
                n++;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("contend_count", n, 4);
        for (int k = 0; k < 4; k++) check("contend_order", g[k], k % 2);
        drain();

        // Backpressure with a competing request pending
        tick();
        bus.rsp_ready  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b01;
        bus.req1_A     = 32'hF0F0F0F0;
        bus.req1_B     = 32'h0FF00FF0;
        wait_grant(1);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b10;
        bus.req0_A     = 32'h00000001;
        bus.req0_B     = 32'h80000000;
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_rsp_S", bus.rsp_S, 32'h00F000F0);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_id", bus.rsp_id, 1);
            check("bp_ready0", bus.req0_ready, 0);
            check("bp_ready1", bus.req1_ready, 0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_valid", bus.rsp_valid, 1);
        check("bp_accept_no_grant", bus.req0_ready, 0);
        @(negedge clk);
        check("bp_next_grant", bus.req0_ready, 1);
        check("bp_next_rsp_valid", bus.rsp_valid, 0);
        tick();
        bus.req0_valid = 1'b0;
        drain();

        // Reset while in RESP
        tick();
        bus.rsp_ready  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b10;
        bus.req1_A     = 32'h00FF00FF;
        bus.req1_B     = 32'h0F0F0F0F;
        wait_grant(1);
        bus.req1_valid = 1'b0;
        wait_rsp();
        tick();
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b01;
        bus.req0_A     = 32'hDEADBEEF;
        bus.req0_B     = 32'hFFFF0000;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b11;
        bus.req1_A     = 32'h13572468;
        bus.req1_B     = 32'hFFFFFFFF;
        @(negedge clk);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rsp_S", bus.rsp_S, 0);
        check("mid_rst_ready0", bus.req0_ready, 1);
        check("mid_rst_ready1", bus.req1_ready, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        wait_grant(1);
        bus.req1_valid = 1'b0;
        drain();

        // Lone requester 1 with the pointer at 0
        tick();
        do_reset();
        bus.rsp_ready  = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b00;
        bus.req1_A     = 32'h12345678;
        @(negedge clk);
        check("lone_ready1", bus.req1_ready, 1);
        check("lone_ready0", bus.req0_ready, 0);
        tick();
        bus.req1_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Shares one 32-bit bitwise logic unit (NOT, AND, OR, XOR) between two independent requesters. Each requester issues operations over a valid/ready handshake. The arbiter grants one request at a time with round-robin fairness, latches its operands, and runs the shared unit for one cycle. It then holds a tagged, registered result until the consumer accepts it. The block sits between the instruction-decode side of the datapath and the shared logic resources.

## Interface
- No parameters; data width fixed at 32, requester count fixed at 2.
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge
- `req0_valid`  in  1  requester 0 has an operation pending
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_op`  in  2  requester 0 opcode
- `req0_A`, `req0_B`  in  32 each  requester 0 operands
- `req1_valid`, `req1_ready`, `req1_op`, `req1_A`, `req1_B`  same as requester 0, for requester 1
- `rsp_valid`  out  1  result held and valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  index of the requester that owns the result
- `rsp_S`  out  32  result word
- `busy`  out  1  high whenever state is not IDLE

## Operation
- Opcodes:
  - 00 = NOT A (B ignored)
  - 01 = A AND B
  - 10 = A OR B
  - 11 = A XOR B
- The FSM has three states; reset enters IDLE.
  - IDLE: if any `reqN_valid` is high, grant one requester and go to EXEC. Otherwise stay in IDLE.
  - EXEC: feed the latched op and operands to the logic unit, register the output into `rsp_S`, and go to RESP.
  - RESP: `rsp_valid` is high. When `rsp_valid && rsp_ready`, go to IDLE. Otherwise hold.
- Grant rule, IDLE only:
  - `reqN_ready` is combinational and high only for the granted requester.
  - On a grant, latch op, A, B and the requester index on that edge.
- Round-robin arbitration:
  - A 1-bit priority pointer names the preferred requester. Its reset value is 0.
  - If both requesters are valid, the preferred one wins.
  - After any grant, the pointer moves to the requester that was not granted.
  - A lone valid requester always wins, whatever the pointer says.
- No request is accepted outside IDLE. Requesters hold valid and operands stable until they see ready.
- Reset values:
  - state = IDLE, pointer = 0
  - `req0_ready` = `req1_ready` = 0
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_S` = 0
  - `busy` = 0
- Reset mid-operation, in EXEC or RESP: the in-flight operation is discarded, no response is issued, and the pointer returns to 0.
- `rsp_S`, `rsp_id` and the latched operands change only on a grant or in EXEC. They are stable throughout RESP.

## Timing
- Latency: grant at edge N, result registered at edge N+1, `rsp_valid` high in cycle N+1. Minimum issue-to-response is 2 cycles.
- Throughput: with `rsp_ready` tied high, the sequence is IDLE→EXEC→RESP→IDLE, so one operation completes every 3 cycles.
- `rsp_ready` low stalls RESP indefinitely with no data loss. Both `reqN_ready` stay 0 during the stall.
- Simultaneous events:
  - `rsp_ready` in RESP and a new valid request: the request is not granted until the following cycle, in IDLE.
  - `reset` and any handshake in the same cycle: `reset` wins.
- `busy` is registered from state only, with no combinational path from inputs.

## Structure
- Shared package `logic_op_pkg` holds:
  - the opcode constants OP_NOT, OP_AND, OP_OR, OP_XOR
  - the FSM state encoding ST_IDLE, ST_EXEC, ST_RESP
  - the data-width constant, 32
- Sub-module `logic_unit_32`: purely combinational, with inputs op[1:0], A[31:0], B[31:0] and output S[31:0]. Build it from the existing 32-bit gate components.
- The arbiter holds the FSM, the pointer, the operand and result registers, and the handshake logic.

## Test plan
- After reset, with no requests: `busy` = 0, `rsp_valid` = 0, both ready = 0 for 5 cycles.
- Single request:
  - Stimulus: req0 op=00, A=32'h0000FFFF, `rsp_ready`=1.
  - Response: `req0_ready` pulses in cycle 0, `rsp_valid` is high in cycle 2 with `rsp_S`=32'hFFFF0000 and `rsp_id`=0.
- Contention:
  - Stimulus: req0 and req1 both held valid with op=11, A=32'hAAAA5555, B=32'hFFFF0000.
  - Response: grants alternate 0,1,0,1. Every result is 32'h55555555, with `rsp_id` alternating.
- Backpressure:
  - Stimulus: req1 op=01, A=32'hF0F0F0F0, B=32'h0FF00FF0, `rsp_ready`=0 for 10 cycles.
  - Response: `rsp_S`=32'h00F000F0 holds stable, no new grants occur, and accept happens on the first `rsp_ready`.
- Reset mid-RESP:
  - Stimulus: req1 op=10, reaching RESP, then assert `reset`.
  - Response: next cycle `rsp_valid`=0 and `busy`=0. A subsequent simultaneous request is granted to requester 0.
- Lone requester: req1 valid with the pointer at 0 is granted immediately, without waiting.
